// File: rtl/monitor_fifos.sv
// rtl/monitor_fifos.sv - occupancy, error and threshold flags for the five switch FIFOs
// Optional MONITOR_STICKY_ERR_EN: FIFO_errors bits latch until reset instead of pulsing.
module monitor_fifos #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] push,
  input  logic [4:0] pop,
  input  logic       active_in,
  input  logic [1:0] Umbral_MF_alto_interno,
  input  logic [1:0] Umbral_MF_bajo_interno,
  input  logic [1:0] Umbral_VC_alto_interno,
  input  logic [1:0] Umbral_VC_bajo_interno,
  input  logic [1:0] Umbral_D_alto_interno,
  input  logic [1:0] Umbral_D_bajo_interno,
  output logic [4:0] FIFO_empties,
  output logic [4:0] FIFO_errors,
  output logic [4:0] almost_full,
  output logic [4:0] almost_empty
);

  // Threshold groups: 0 = MF, 1 = VC0/VC1, 2 = D0/D1
  logic       active_q;
  logic [1:0] alto_q [3];
  logic [1:0] bajo_q [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      for (int g = 0; g < 3; g++) begin
        alto_q[g] <= 2'd3;
        bajo_q[g] <= 2'd1;
      end
    end else begin
      active_q <= active_in;
      if (active_in && !active_q) begin
        alto_q[0] <= Umbral_MF_alto_interno;
        bajo_q[0] <= Umbral_MF_bajo_interno;
        alto_q[1] <= Umbral_VC_alto_interno;
        bajo_q[1] <= Umbral_VC_bajo_interno;
        alto_q[2] <= Umbral_D_alto_interno;
        bajo_q[2] <= Umbral_D_bajo_interno;
      end
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_fifo
    localparam int G = (i == 0) ? 0 : ((i < 3) ? 1 : 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt;
    logic          err;
    logic          empty_q;
    logic          err_q;
    logic          af_q;
    logic          ae_q;

    always_comb begin
      nxt = cnt;
      err = 1'b0;
      case ({push[i], pop[i]})
        2'b10: begin
          if (cnt == CW'(DEPTH)) err = 1'b1;
          else                   nxt = cnt + CW'(1);
        end
        2'b01: begin
          if (cnt == '0) err = 1'b1;
          else           nxt = cnt - CW'(1);
        end
        2'b11: begin
          // Pop on empty underflows, but the push still lands
          if (cnt == '0) begin
            err = 1'b1;
            nxt = CW'(1);
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= '0;
        empty_q <= 1'b1;
        err_q   <= 1'b0;
        af_q    <= 1'b0;
        ae_q    <= 1'b1;
      end else begin
        cnt     <= nxt;
        empty_q <= (nxt == '0);
        af_q    <= (nxt > CW'(alto_q[G]));
        ae_q    <= (nxt <= CW'(bajo_q[G]));
`ifdef MONITOR_STICKY_ERR_EN
        err_q   <= err_q | err;
`else
        err_q   <= err;
`endif
      end
    end

    assign FIFO_empties[i] = empty_q;
    assign FIFO_errors[i]  = err_q;
    assign almost_full[i]  = af_q;
    assign almost_empty[i] = ae_q;
  end

endmodule

// File: tb/tb_monitor_fifos.sv
// tb/tb_monitor_fifos.sv - directed and randomized checks of monitor_fifos against a count model
module tb_monitor_fifos;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] push = '0;
  logic [4:0] pop = '0;
  logic       active_in = 1'b0;
  logic [1:0] u_alto [3];
  logic [1:0] u_bajo [3];
  logic [4:0] FIFO_empties, FIFO_errors, almost_full, almost_empty;

  int total = 0;
  int bad = 0;

  // Reference model state
  int         m_cnt [5];
  int         m_alto [3];
  int         m_bajo [3];
  bit         m_prev;
  logic [4:0] exp_empt, exp_err, exp_af, exp_ae;

  always #5 clk = ~clk;

  monitor_fifos #(.DEPTH(DEPTH), .CW(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .active_in(active_in),
    .Umbral_MF_alto_interno(u_alto[0]), .Umbral_MF_bajo_interno(u_bajo[0]),
    .Umbral_VC_alto_interno(u_alto[1]), .Umbral_VC_bajo_interno(u_bajo[1]),
    .Umbral_D_alto_interno(u_alto[2]),  .Umbral_D_bajo_interno(u_bajo[2]),
    .FIFO_empties(FIFO_empties), .FIFO_errors(FIFO_errors),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  function automatic int grp(input int i);
    return (i == 0) ? 0 : ((i < 3) ? 1 : 2);
  endfunction

  task automatic model_step();
    bit e;
    if (reset) begin
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      for (int g = 0; g < 3; g++) begin m_alto[g] = 3; m_bajo[g] = 1; end
      m_prev = 0;
      exp_empt = 5'b11111; exp_err = 5'b0; exp_af = 5'b0; exp_ae = 5'b11111;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      e = 0;
      if (push[i] && pop[i]) begin
        if (m_cnt[i] == 0) begin e = 1; m_cnt[i] = 1; end
      end else if (push[i]) begin
        if (m_cnt[i] == DEPTH) e = 1; else m_cnt[i]++;
      end else if (pop[i]) begin
        if (m_cnt[i] == 0) e = 1; else m_cnt[i]--;
      end
`ifdef MONITOR_STICKY_ERR_EN
      exp_err[i] = exp_err[i] | e;
`else
      exp_err[i] = e;
`endif
      exp_empt[i] = (m_cnt[i] == 0);
      exp_af[i]   = (m_cnt[i] > m_alto[grp(i)]);
      exp_ae[i]   = (m_cnt[i] <= m_bajo[grp(i)]);
    end
    if (active_in && !m_prev)
      for (int g = 0; g < 3; g++) begin m_alto[g] = u_alto[g]; m_bajo[g] = u_bajo[g]; end
    m_prev = active_in;
  endtask

  task automatic tick(input logic [4:0] p, input logic [4:0] q);
    push = p; pop = q;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; active_in = 1'b0;
    tick(5'b0, 5'b0); tick(5'b0, 5'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (FIFO_empties !== 5'b11111) begin bad++; $display("FAIL reset_empties got=%b exp=%b", FIFO_empties, 5'b11111); end
    total++; if (FIFO_errors !== 5'b00000) begin bad++; $display("FAIL reset_errors got=%b exp=%b", FIFO_errors, 5'b00000); end
    total++; if (almost_full !== 5'b00000) begin bad++; $display("FAIL reset_af got=%b exp=%b", almost_full, 5'b00000); end
    total++; if (almost_empty !== 5'b11111) begin bad++; $display("FAIL reset_ae got=%b exp=%b", almost_empty, 5'b11111); end
  endtask

  task automatic test_fill_mf();
    do_reset();
    tick(5'b00001, 5'b0);
    tick(5'b00001, 5'b0);
    total++; if (almost_empty[0] !== 1'b0) begin bad++; $display("FAIL fill_ae_after2 got=%b exp=0", almost_empty[0]); end
    tick(5'b00001, 5'b0);
    total++; if (almost_full[0] !== 1'b0) begin bad++; $display("FAIL fill_af_after3 got=%b exp=0", almost_full[0]); end
    tick(5'b00001, 5'b0);
    total++; if (almost_full[0] !== 1'b1) begin bad++; $display("FAIL fill_af_after4 got=%b exp=1", almost_full[0]); end
    tick(5'b00001, 5'b0);
    total++; if (FIFO_errors[0] !== 1'b1) begin bad++; $display("FAIL overflow_err got=%b exp=1", FIFO_errors[0]); end
    for (int k = 0; k < 3; k++) tick(5'b0, 5'b00001);
    total++; if (FIFO_empties[0] !== 1'b0) begin bad++; $display("FAIL drain_3_empty got=%b exp=0", FIFO_empties[0]); end
    tick(5'b0, 5'b00001);
    total++; if (FIFO_empties[0] !== 1'b1) begin bad++; $display("FAIL drain_4_empty got=%b exp=1", FIFO_empties[0]); end
  endtask

  task automatic test_underflow();
    do_reset();
    tick(5'b10000, 5'b10000);
    total++; if (FIFO_errors[4] !== 1'b1) begin bad++; $display("FAIL uflow_err got=%b exp=1", FIFO_errors[4]); end
    total++; if (FIFO_empties[4] !== 1'b0) begin bad++; $display("FAIL uflow_empty got=%b exp=0", FIFO_empties[4]); end
    tick(5'b0, 5'b0);
`ifdef MONITOR_STICKY_ERR_EN
    total++; if (FIFO_errors[4] !== 1'b1) begin bad++; $display("FAIL uflow_sticky got=%b exp=1", FIFO_errors[4]); end
`else
    total++; if (FIFO_errors[4] !== 1'b0) begin bad++; $display("FAIL uflow_pulse got=%b exp=0", FIFO_errors[4]); end
`endif
  endtask

  task automatic test_capture();
    do_reset();
    u_alto[1] = 2'd1;
    tick(5'b0, 5'b0);
    active_in = 1'b1;
    tick(5'b0, 5'b0);
    tick(5'b00010, 5'b0);
    total++; if (almost_full[1] !== 1'b0) begin bad++; $display("FAIL cap_af_at1 got=%b exp=0", almost_full[1]); end
    tick(5'b00010, 5'b0);
    total++; if (almost_full[1] !== 1'b1) begin bad++; $display("FAIL cap_af_at2 got=%b exp=1", almost_full[1]); end
    u_alto[1] = 2'd3;
    tick(5'b0, 5'b0);
    tick(5'b0, 5'b0);
    total++; if (almost_full[1] !== 1'b1) begin bad++; $display("FAIL cap_ignored got=%b exp=1", almost_full[1]); end
    active_in = 1'b0;
    u_alto[1] = 2'd3;
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int k = 0; k < 4; k++) tick(5'b00100, 5'b0);
    tick(5'b00100, 5'b00100);
    total++; if (FIFO_errors[2] !== 1'b0) begin bad++; $display("FAIL fullpp_err got=%b exp=0", FIFO_errors[2]); end
    total++; if (almost_full[2] !== 1'b1) begin bad++; $display("FAIL fullpp_af got=%b exp=1", almost_full[2]); end
    tick(5'b0, 5'b00100);
    total++; if (almost_full[2] !== 1'b0) begin bad++; $display("FAIL fullpp_pop_af got=%b exp=0", almost_full[2]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    u_alto[0] = 2'd0; u_bajo[0] = 2'd0;
    active_in = 1'b1;
    tick(5'b0, 5'b0);
    for (int k = 0; k < 3; k++) tick(5'b00001, 5'b0);
    reset = 1'b1; active_in = 1'b0;
    tick(5'b0, 5'b0);
    reset = 1'b0;
    total++; if (FIFO_empties[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_empty got=%b exp=1", FIFO_empties[0]); end
    tick(5'b00001, 5'b0);
    total++; if (almost_empty[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_bajo got=%b exp=1", almost_empty[0]); end
    tick(5'b00001, 5'b0);
    tick(5'b00001, 5'b0);
    total++; if (almost_full[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_alto got=%b exp=0", almost_full[0]); end
    u_alto[0] = 2'd3; u_bajo[0] = 2'd1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) active_in = ~active_in;
      for (int g = 0; g < 3; g++) begin
        u_alto[g] = 2'($urandom_range(0, 3));
        u_bajo[g] = 2'($urandom_range(0, 3));
      end
      tick(5'($urandom), 5'($urandom));
      total++; if (FIFO_empties !== exp_empt) begin bad++; $display("FAIL rnd_empties cyc=%0d got=%b exp=%b", n, FIFO_empties, exp_empt); end
      total++; if (FIFO_errors !== exp_err) begin bad++; $display("FAIL rnd_errors cyc=%0d got=%b exp=%b", n, FIFO_errors, exp_err); end
      total++; if (almost_full !== exp_af) begin bad++; $display("FAIL rnd_af cyc=%0d got=%b exp=%b", n, almost_full, exp_af); end
      total++; if (almost_empty !== exp_ae) begin bad++; $display("FAIL rnd_ae cyc=%0d got=%b exp=%b", n, almost_empty, exp_ae); end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin u_alto[g] = 2'd3; u_bajo[g] = 2'd1; end
    test_reset();
    test_fill_mf();
    test_underflow();
    test_capture();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
